// File: rtl/tpu_out_writer.sv
// Output write-back stage: takes 4-lane tile rows from the systolic drain and
// packs them into 32-bit GBUFF_OUT words (8-bit truncation, row-major layout).
module tpu_out_writer #(
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 16,
    parameter int WORD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           m,
    input  logic [3:0]           n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*ACC_W-1:0]   in_data,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    index,
    output logic [WORD_W-1:0]    data_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [3:0] m_q, m_d;
    logic [3:0] n_q, n_d;
    logic [2:0] ro_q, ro_d;
    logic [2:0] tr_q, tr_d;
    logic [1:0] row_q, row_d;
    logic [1:0] tcol_q, tcol_d;
    logic [1:0] trow_q, trow_d;

    logic              wr_en_q;
    logic [ADDR_W-1:0] index_q;
    logic [WORD_W-1:0] data_q;

    logic accept;
    logic tcol_end;
    logic trow_end;
    logic last_beat;
    logic row_ok;
    logic [3:0]        r_cur;
    logic [6:0]        idx_calc;
    logic [2:0]        ro_start;
    logic [2:0]        tr_start;
    logic [WORD_W-1:0] packed_word;
    logic              unused_in;

    // Only the low byte of each accumulator lane is written out.
    assign unused_in = ^in_data;

    assign accept    = (state_q == S_RUN) && in_valid;
    assign tcol_end  = ({1'b0, tcol_q} == (ro_q - 3'd1));
    assign trow_end  = ({1'b0, trow_q} == (tr_q - 3'd1));
    assign last_beat = (row_q == 2'd3) && tcol_end && trow_end;

    assign ro_start  = 3'(({1'b0, n} + 5'd3) >> 2);
    assign tr_start  = 3'(({1'b0, m} + 5'd3) >> 2);

    assign r_cur     = {trow_q, row_q};
    assign row_ok    = (r_cur < m_q);
    assign idx_calc  = ({3'b000, r_cur} * {4'b0000, ro_q}) + {5'b00000, tcol_q};

    // Columns past n inside the last tile column are padding and written as zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [3:0] col;
            assign col = {tcol_q, LANE};
            assign packed_word[8*gi +: 8] =
                (col < n_q) ? in_data[gi*ACC_W +: 8] : 8'h00;
        end
        if (WORD_W > 32) begin : g_pad
            assign packed_word[WORD_W-1:32] = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        ro_d    = ro_q;
        tr_d    = tr_q;
        row_d   = row_q;
        tcol_d  = tcol_q;
        trow_d  = trow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d    = m;
                    n_d    = n;
                    ro_d   = ro_start;
                    tr_d   = tr_start;
                    row_d  = 2'd0;
                    tcol_d = 2'd0;
                    trow_d = 2'd0;
                    state_d = ((m == 4'd0) || (n == 4'd0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = S_FLUSH;
                        row_d   = 2'd0;
                        tcol_d  = 2'd0;
                        trow_d  = 2'd0;
                    end else if (row_q == 2'd3) begin
                        row_d = 2'd0;
                        if (tcol_end) begin
                            tcol_d = 2'd0;
                            trow_d = trow_q + 2'd1;
                        end else begin
                            tcol_d = tcol_q + 2'd1;
                        end
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= 4'd0;
            n_q     <= 4'd0;
            ro_q    <= 3'd0;
            tr_q    <= 3'd0;
            row_q   <= 2'd0;
            tcol_q  <= 2'd0;
            trow_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            ro_q    <= ro_d;
            tr_q    <= tr_d;
            row_q   <= row_d;
            tcol_q  <= tcol_d;
            trow_q  <= trow_d;
        end
    end

    // Beats for padding rows are consumed without a write; address/data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            wr_en_q <= accept && row_ok;
            if (accept && row_ok) begin
                index_q <= {{(ADDR_W-7){1'b0}}, idx_calc};
                data_q  <= packed_word;
            end
        end
    end

    assign in_ready = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done     = (state_q == S_DONE);
    assign wr_en    = wr_en_q;
    assign index    = index_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_tpu_out_writer.sv
// Randomized bench for tpu_out_writer: matrix-level reference of GBUFF_OUT
// contents plus a cycle monitor checking write timing and address order.
module tb_tpu_out_writer;

    localparam int ACC_W  = 16;
    localparam int ADDR_W = 16;
    localparam int WORD_W = 32;

    logic               clk;
    logic               rst;
    logic               start;
    logic [3:0]         m;
    logic [3:0]         n;
    logic               in_valid;
    logic               in_ready;
    logic [4*ACC_W-1:0] in_data;
    logic               wr_en;
    logic [ADDR_W-1:0]  index;
    logic [WORD_W-1:0]  data_out;
    logic               busy;
    logic               done;

    tpu_out_writer #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m        (m),
        .n        (n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .index    (index),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Result matrix C including padding positions up to 16x16.
    logic [15:0] cmat [0:15][0:15];
    logic [31:0] dut_mem [0:63];

    typedef struct {
        bit we;
        int idx;
    } beat_t;

    beat_t beat_q[$];
    bit    pend = 1'b0;
    beat_t pend_b;
    int    wr_count   = 0;
    int    done_count = 0;

    always @(negedge clk) begin
        if (pend) begin
            check_val("wr_en", {31'd0, wr_en}, {31'd0, pend_b.we});
            if (pend_b.we) check_val("index", {16'd0, index}, pend_b.idx);
        end else begin
            check_val("no_spurious_wr", {31'd0, wr_en}, 32'd0);
        end
        if (wr_en) begin
            wr_count++;
            if (index < 16'd64) dut_mem[index[5:0]] = data_out;
        end
        if (done) done_count++;
        pend = in_valid && in_ready && !rst;
        if (pend) begin
            if (beat_q.size() == 0) begin
                check_val("beat_queue_empty", 32'd1, 32'd0);
                pend = 1'b0;
            end else begin
                pend_b = beat_q.pop_front();
            end
        end
    end

    task automatic fill_random();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                cmat[r][c] = 16'($urandom);
    endtask

    task automatic fill_seq4();
        fill_random();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                cmat[r][c] = 16'(r * 4 + c + 1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) dut_mem[i] = 32'hDEADBEEF;
        wr_count   = 0;
        done_count = 0;
    endtask

    task automatic pulse_start(input int mm, input int nn);
        @(posedge clk);
        #1;
        start = 1'b1;
        m     = 4'(mm);
        n     = 4'(nn);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one tile row and holds it until accepted.
    task automatic drive_beat(input int r, input int tcol, input int mm, input int ro,
                              input int stall, input bit start_now, inout int cyc);
        beat_t b;
        bit v, rdy, accepted;
        int tries;
        b.we  = (r < mm);
        b.idx = r * ro + tcol;
        beat_q.push_back(b);
        for (int j = 0; j < 4; j++) in_data[j*ACC_W +: ACC_W] = cmat[r][tcol*4 + j];
        accepted = 1'b0;
        tries = 0;
        while (!accepted) begin
            case (stall)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            if (start_now && v) begin
                start = 1'b1;
                m = 4'($urandom_range(1, 15));
                n = 4'($urandom_range(1, 15));
            end
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            accepted = v && rdy;
            tries++;
            if (tries > 100) begin
                $display("FAIL in_ready_timeout r=%0d tcol=%0d", r, tcol);
                $fatal(1, "in_ready never asserted");
            end
        end
        in_valid = 1'b0;
        in_data  = 64'($urandom) << 32 | 64'($urandom);
    endtask

    task automatic run_job(input int mm, input int nn, input int stall, input bit busy_start);
        int ro, tr, cyc, beatno;
        logic [31:0] exp_w;
        ro = (nn + 3) / 4;
        tr = (mm + 3) / 4;
        clear_mem();
        pulse_start(mm, nn);
        check_val("busy_after_start", {31'd0, busy}, 32'd1);
        cyc = 0;
        beatno = 0;
        for (int trow = 0; trow < tr; trow++)
            for (int tcol = 0; tcol < ro; tcol++)
                for (int rr = 0; rr < 4; rr++) begin
                    drive_beat(trow * 4 + rr, tcol, mm, ro, stall,
                               busy_start && (beatno == 5), cyc);
                    beatno++;
                end
        @(negedge clk);
        check_val("done_in_flush", {31'd0, done}, 32'd0);
        check_val("busy_in_flush", {31'd0, busy}, 32'd1);
        check_val("ready_dropped", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check_val("done_pulse", {31'd0, done}, 32'd1);
        check_val("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val("done_cleared", {31'd0, done}, 32'd0);
        for (int r = 0; r < mm; r++)
            for (int w = 0; w < ro; w++) begin
                for (int j = 0; j < 4; j++)
                    exp_w[8*j +: 8] = (4*w + j < nn) ? cmat[r][4*w + j][7:0] : 8'h00;
                check_val("mem_word", dut_mem[r*ro + w], exp_w);
            end
        check_val("write_count", wr_count, mm * ro);
        check_val("done_count", done_count, 32'd1);
        $display("job m=%0d n=%0d stall=%0d beats=%0d writes=%0d",
                 mm, nn, stall, beatno, wr_count);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        m        = 4'd0;
        n        = 4'd0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check_val("rst_index", {16'd0, index}, 32'd0);
        check_val("rst_data", data_out, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);

        fill_seq4();
        run_job(4, 4, 0, 1'b0);
        check_val("seq_idx0", dut_mem[0], 32'h04030201);
        check_val("seq_idx1", dut_mem[1], 32'h08070605);
        check_val("seq_idx2", dut_mem[2], 32'h0C0B0A09);
        check_val("seq_idx3", dut_mem[3], 32'h100F0E0D);

        fill_random();
        cmat[0][8] = 16'h0133;
        run_job(5, 9, 0, 1'b0);
        check_val("m5n9_col2", dut_mem[2], 32'h00000033);

        fill_random();
        cmat[0][0] = 16'h01FF;
        cmat[0][1] = 16'h0100;
        cmat[0][2] = 16'hFF80;
        cmat[0][3] = 16'h007F;
        run_job(1, 4, 0, 1'b0);
        check_val("trunc_word", dut_mem[0], 32'h7F8000FF);

        fill_seq4();
        run_job(4, 4, 1, 1'b0);
        check_val("stall_idx0", dut_mem[0], 32'h04030201);
        check_val("stall_idx3", dut_mem[3], 32'h100F0E0D);

        // n=0: straight to DONE; a start coinciding with done must be ignored.
        clear_mem();
        pulse_start(3, 0);
        start = 1'b1;
        m = 4'd4;
        n = 4'd4;
        @(negedge clk);
        check_val("n0_done", {31'd0, done}, 32'd1);
        check_val("n0_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_val("start_on_done_busy", {31'd0, busy}, 32'd0);
        check_val("start_on_done_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check_val("n0_idle_busy", {31'd0, busy}, 32'd0);
        check_val("n0_writes", wr_count, 32'd0);
        check_val("n0_done_count", done_count, 32'd1);
        $display("job m=3 n=0 writes=%0d", wr_count);

        fill_random();
        run_job(7, 11, 2, 1'b1);

        // Abort after two beats; the third beat coincides with rst and is dropped.
        begin
            int cyc;
            cyc = 0;
            fill_seq4();
            clear_mem();
            pulse_start(4, 4);
            drive_beat(0, 0, 4, 1, 0, 1'b0, cyc);
            drive_beat(1, 0, 4, 1, 0, 1'b0, cyc);
            in_valid = 1'b1;
            for (int j = 0; j < 4; j++) in_data[j*ACC_W +: ACC_W] = cmat[2][j];
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            check_val("abort_wr_en", {31'd0, wr_en}, 32'd0);
            check_val("abort_busy", {31'd0, busy}, 32'd0);
            check_val("abort_ready", {31'd0, in_ready}, 32'd0);
            check_val("abort_writes", wr_count, 32'd2);
            beat_q.delete();
            $display("job m=4 n=4 aborted after 2 beats writes=%0d", wr_count);
        end
        fill_random();
        cmat[0][0] = 16'h55AA;
        cmat[0][1] = 16'h1111;
        cmat[0][2] = 16'h2222;
        cmat[0][3] = 16'h3333;
        run_job(1, 1, 0, 1'b0);
        check_val("after_abort_idx0", dut_mem[0], 32'h000000AA);
        check_val("after_abort_idx1", dut_mem[1], 32'hDEADBEEF);

        for (int k = 0; k < 6; k++) begin
            fill_random();
            if (k == 0) run_job(15, 15, 2, 1'b0);
            else run_job($urandom_range(1, 15), $urandom_range(1, 15), $urandom_range(0, 2), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
